l1_biu: RTL and testbench

L1_BIU -- requirements
Module: l1_biu

---
 rtl/l1_biu_pkg.sv | 17 +
 rtl/l1_biu_watchdog.sv | 41 ++++
 rtl/l1_biu.sv | 189 ++++++++++++++++++
 tb/tb_l1_biu.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l1_biu_pkg.sv
// Shared state encoding and default geometry for the L1 bus interface unit.
package l1_biu_pkg;

  localparam int DEF_ADDR_WIDTH = 24;
  localparam int DEF_LINE_WID   = 7;
  localparam int DEF_TIMEOUT    = 255;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LINE_RD = 3'd1,
    ST_SGL_RD  = 3'd2,
    ST_SGL_WR  = 3'd3,
    ST_DONE    = 3'd4,
    ST_FAULT   = 3'd5
  } state_e;

endpackage

// File: rtl/l1_biu_watchdog.sv
// Saturating count of consecutive bus_req cycles that have not been acknowledged.
module biu_watchdog
  import l1_biu_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TC_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] TC_SAT  = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run && (cnt_q != TC_SAT)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires in the last un-acked cycle so bus_req is high for exactly TIMEOUT cycles.
  assign expired = run && (cnt_q >= TC_LAST);

endmodule

// File: rtl/l1_biu.sv
// L1 cache bus interface: line fills, single reads and write-through writes.
// state   | meaning
// IDLE    | waiting for a cache request
// LINE_RD | streaming 2^LINE_WID byte reads of one line
// SGL_RD  | one byte read at pa
// SGL_WR  | one byte write-through at pa
// DONE    | one-cycle guard against stale request levels
// FAULT   | bus error or timeout, bus_error pulses here
module l1_biu
  import l1_biu_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int LINE_WID   = DEF_LINE_WID,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_through_req,
  input  logic                  read_req,
  input  logic                  read_line_req,
  input  logic [ADDR_WIDTH-1:0] pa,
  input  logic [7:0]            wt_data,
  output logic [7:0]            line_data,
  output logic [LINE_WID-1:0]   addr_count,
  output logic                  line_write,
  output logic                  cache_entry_refill,
  output logic                  trans_rdy,
  output logic                  bus_error,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [7:0]            bus_wdata,
  input  logic [7:0]            bus_rdata,
  input  logic                  bus_ack,
  input  logic                  bus_err
);

  localparam int BW = ADDR_WIDTH - LINE_WID;
  localparam logic [LINE_WID-1:0] BEAT_ONE = LINE_WID'(1);

  state_e                state_q, state_d;
  logic                  bus_req_q, bus_req_d;
  logic                  bus_we_q, bus_we_d;
  logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
  logic [7:0]            bus_wdata_q, bus_wdata_d;
  logic [7:0]            line_data_q, line_data_d;
  logic [LINE_WID-1:0]   addr_count_q, addr_count_d;
  logic                  line_write_q, line_write_d;
  logic                  refill_q, refill_d;
  logic                  trans_rdy_q, trans_rdy_d;
  logic                  bus_error_q, bus_error_d;
  logic [BW-1:0]         base_q, base_d;
  logic [LINE_WID-1:0]   beat_q, beat_d;
  logic [LINE_WID-1:0]   beat_nxt;
  logic                  wd_clear, wd_run, wd_expired, bus_fail;

  assign wd_clear = ~bus_req_q | bus_ack | bus_err;
  assign wd_run   = bus_req_q & ~bus_ack & ~bus_err;

  biu_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (wd_clear),
    .run     (wd_run),
    .expired (wd_expired)
  );

  // bus_err wins over a simultaneous bus_ack.
  assign bus_fail = bus_err | wd_expired;
  assign beat_nxt = beat_q + BEAT_ONE;

  always_comb begin
    state_d      = state_q;
    bus_req_d    = bus_req_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    line_data_d  = line_data_q;
    addr_count_d = addr_count_q;
    base_d       = base_q;
    beat_d       = beat_q;
    line_write_d = 1'b0;
    refill_d     = 1'b0;
    trans_rdy_d  = 1'b0;
    bus_error_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (read_line_req) begin
          state_d    = ST_LINE_RD;
          bus_req_d  = 1'b1;
          bus_we_d   = 1'b0;
          base_d     = pa[ADDR_WIDTH-1:LINE_WID];
          beat_d     = '0;
          bus_addr_d = {pa[ADDR_WIDTH-1:LINE_WID], {LINE_WID{1'b0}}};
        end else if (read_req) begin
          state_d    = ST_SGL_RD;
          bus_req_d  = 1'b1;
          bus_we_d   = 1'b0;
          bus_addr_d = pa;
        end else if (write_through_req) begin
          state_d     = ST_SGL_WR;
          bus_req_d   = 1'b1;
          bus_we_d    = 1'b1;
          bus_addr_d  = pa;
          bus_wdata_d = wt_data;
        end
      end
      ST_LINE_RD, ST_SGL_RD, ST_SGL_WR: begin
        if (bus_fail) begin
          state_d     = ST_FAULT;
          bus_req_d   = 1'b0;
          bus_we_d    = 1'b0;
          bus_error_d = 1'b1;
        end else if (bus_ack) begin
          if (state_q == ST_LINE_RD) begin
            line_data_d  = bus_rdata;
            addr_count_d = beat_q;
            line_write_d = 1'b1;
            if (&beat_q) begin
              refill_d    = 1'b1;
              trans_rdy_d = 1'b1;
              bus_req_d   = 1'b0;
              state_d     = ST_DONE;
            end else begin
              beat_d     = beat_nxt;
              bus_addr_d = {base_q, beat_nxt};
            end
          end else begin
            if (state_q == ST_SGL_RD) begin
              line_data_d = bus_rdata;
            end
            trans_rdy_d = 1'b1;
            bus_req_d   = 1'b0;
            bus_we_d    = 1'b0;
            state_d     = ST_DONE;
          end
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_FAULT: state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      line_data_q  <= '0;
      addr_count_q <= '0;
      line_write_q <= 1'b0;
      refill_q     <= 1'b0;
      trans_rdy_q  <= 1'b0;
      bus_error_q  <= 1'b0;
      base_q       <= '0;
      beat_q       <= '0;
    end else begin
      state_q      <= state_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      line_data_q  <= line_data_d;
      addr_count_q <= addr_count_d;
      line_write_q <= line_write_d;
      refill_q     <= refill_d;
      trans_rdy_q  <= trans_rdy_d;
      bus_error_q  <= bus_error_d;
      base_q       <= base_d;
      beat_q       <= beat_d;
    end
  end

  assign bus_req            = bus_req_q;
  assign bus_we             = bus_we_q;
  assign bus_addr           = bus_addr_q;
  assign bus_wdata          = bus_wdata_q;
  assign line_data          = line_data_q;
  assign addr_count         = addr_count_q;
  assign line_write         = line_write_q;
  assign cache_entry_refill = refill_q;
  assign trans_rdy          = trans_rdy_q;
  assign bus_error          = bus_error_q;

endmodule

// File: tb/tb_l1_biu.sv
// Scoreboard bench for l1_biu: bus responder plus response monitor fed by directed scenarios.
module tb_l1_biu;

  typedef struct {
    logic [23:0] addr;
    logic        we;
    logic [7:0]  wdata;
  } bus_exp_t;

  typedef struct {
    logic [7:0] ld;
    logic       chk_ld;
    logic [6:0] ac;
    logic       chk_ac;
    logic       lw;
    logic       refill;
    logic       trdy;
    logic       err;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        write_through_req, read_req, read_line_req;
  logic [23:0] pa;
  logic [7:0]  wt_data;
  logic [7:0]  line_data;
  logic [6:0]  addr_count;
  logic        line_write, cache_entry_refill, trans_rdy, bus_error;
  logic        bus_req, bus_we;
  logic [23:0] bus_addr;
  logic [7:0]  bus_wdata, bus_rdata;
  logic        bus_ack, bus_err;

  bus_exp_t exp_bus_q[$];
  resp_t    exp_resp_q[$];

  int tests = 0;
  int fails = 0;
  int lw_count = 0;
  int ack_wait = 0;
  bit never_ack = 1'b0;
  int err_beat = -1;
  bit rdata_lowaddr = 1'b1;
  logic [7:0] fixed_rdata = 8'h00;
  int beat_idx = 0;
  int wait_cnt = 0;
  int req_run = 0;
  int last_req_run = 0;

  l1_biu dut (
    .clk                (clk),
    .rst                (rst),
    .write_through_req  (write_through_req),
    .read_req           (read_req),
    .read_line_req      (read_line_req),
    .pa                 (pa),
    .wt_data            (wt_data),
    .line_data          (line_data),
    .addr_count         (addr_count),
    .line_write         (line_write),
    .cache_entry_refill (cache_entry_refill),
    .trans_rdy          (trans_rdy),
    .bus_error          (bus_error),
    .bus_req            (bus_req),
    .bus_we             (bus_we),
    .bus_addr           (bus_addr),
    .bus_wdata          (bus_wdata),
    .bus_rdata          (bus_rdata),
    .bus_ack            (bus_ack),
    .bus_err            (bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_end(input string name, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (trans_rdy || bus_error) begin
        seen = 1'b1;
        break;
      end
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL %s: no trans_rdy/bus_error within %0d cycles", name, budget);
    end
  endtask

  task automatic push_bus(input logic [23:0] a, input logic we, input logic [7:0] wd);
    bus_exp_t be;
    be.addr = a; be.we = we; be.wdata = wd;
    exp_bus_q.push_back(be);
  endtask

  task automatic push_resp(input logic [7:0] ld, input logic chk_ld, input logic [6:0] ac,
                           input logic chk_ac, input logic lw, input logic refill,
                           input logic trdy, input logic err);
    resp_t r;
    r.ld = ld; r.chk_ld = chk_ld; r.ac = ac; r.chk_ac = chk_ac;
    r.lw = lw; r.refill = refill; r.trdy = trdy; r.err = err;
    exp_resp_q.push_back(r);
  endtask

  // Bus responder: checks each presented beat against the expected queue, acks after ack_wait cycles.
  initial begin
    bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = 8'h00;
    forever begin
      @(negedge clk);
      bus_ack = 1'b0;
      bus_err = 1'b0;
      if (!rst) begin
        wait_cnt = 0;
        req_run = 0;
      end else if (bus_req) begin
        req_run++;
        if (exp_bus_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL bus_unexpected: actual bus_req=1 addr 0x%0h required no transaction", bus_addr);
        end else begin
          check("bus_addr", bus_addr, exp_bus_q[0].addr);
          check("bus_we", bus_we, exp_bus_q[0].we);
          if (exp_bus_q[0].we) check("bus_wdata", bus_wdata, exp_bus_q[0].wdata);
          if (!never_ack && wait_cnt >= ack_wait) begin
            if (beat_idx == err_beat) begin
              bus_err = 1'b1;
            end else begin
              bus_ack = 1'b1;
              bus_rdata = rdata_lowaddr ? bus_addr[7:0] : fixed_rdata;
            end
            void'(exp_bus_q.pop_front());
            beat_idx++;
            wait_cnt = 0;
            req_run = 0;
          end else begin
            wait_cnt++;
          end
        end
      end else begin
        if (req_run != 0) last_req_run = req_run;
        req_run = 0;
        wait_cnt = 0;
      end
    end
  end

  // Response monitor: every strobe cycle is matched against the next expected response.
  initial begin
    resp_t r;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && (line_write || cache_entry_refill || trans_rdy || bus_error)) begin
        if (line_write) lw_count++;
        if (exp_resp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL resp_unexpected: actual lw=%0b refill=%0b trdy=%0b err=%0b required no strobe",
                   line_write, cache_entry_refill, trans_rdy, bus_error);
        end else begin
          r = exp_resp_q.pop_front();
          check("resp_line_write", line_write, r.lw);
          check("resp_refill", cache_entry_refill, r.refill);
          check("resp_trans_rdy", trans_rdy, r.trdy);
          check("resp_bus_error", bus_error, r.err);
          if (r.chk_ld) check("resp_line_data", line_data, r.ld);
          if (r.chk_ac) check("resp_addr_count", addr_count, r.ac);
        end
      end
    end
  end

  task automatic run_line(input logic [23:0] a, input int errb, input bit also_lower);
    logic [23:0] base, ba;
    int nlw, nbus;
    base = a & 24'hFFFF80;
    nlw  = (errb < 0) ? 128 : errb;
    nbus = (errb < 0) ? 128 : errb + 1;
    ack_wait = 0; never_ack = 1'b0; err_beat = errb; rdata_lowaddr = 1'b1;
    beat_idx = 0; lw_count = 0;
    for (int k = 0; k < nbus; k++) push_bus(base | 24'(k), 1'b0, 8'h00);
    for (int k = 0; k < nlw; k++) begin
      ba = base | 24'(k);
      push_resp(ba[7:0], 1'b1, 7'(k), 1'b1, 1'b1, (errb < 0) && (k == 127), (errb < 0) && (k == 127), 1'b0);
    end
    if (errb >= 0) push_resp(8'h00, 1'b0, 7'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    pa = a; wt_data = 8'h99;
    read_line_req = 1'b1; read_req = also_lower; write_through_req = also_lower;
    @(posedge clk); #1;
    check("line_req_latency", bus_req, 1'b1);
    wait_end("line_done", 200);
    read_line_req = 1'b0; read_req = 1'b0; write_through_req = 1'b0;
    idle(4);
    check("line_lw_count", lw_count, nlw);
    check("line_resp_drained", exp_resp_q.size(), 0);
    check("line_bus_drained", exp_bus_q.size(), 0);
    check("line_idle_bus_req", bus_req, 1'b0);
  endtask

  task automatic run_single(input logic [23:0] a, input bit rd, input bit wt, input logic [7:0] wd,
                            input logic [7:0] rdat, input int w, input bit hold_after);
    ack_wait = w; never_ack = 1'b0; err_beat = -1; rdata_lowaddr = 1'b0; fixed_rdata = rdat;
    beat_idx = 0; lw_count = 0;
    push_bus(a, !rd, wd);
    push_resp(rdat, rd, 7'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    pa = a; wt_data = wd; read_req = rd; write_through_req = wt;
    @(posedge clk); #1;
    check("single_req_latency", bus_req, 1'b1);
    wait_end("single_done", 40);
    if (hold_after) begin
      @(posedge clk); #1;
    end
    read_req = 1'b0; write_through_req = 1'b0;
    idle(4);
    check("single_lw_count", lw_count, 0);
    check("single_resp_drained", exp_resp_q.size(), 0);
    check("single_idle_bus_req", bus_req, 1'b0);
    check("single_idle_bus_we", bus_we, 1'b0);
  endtask

  task automatic run_timeout(input logic [23:0] a);
    never_ack = 1'b1; err_beat = -1; last_req_run = 0; lw_count = 0;
    push_bus(a, 1'b0, 8'h00);
    push_resp(8'h00, 1'b0, 7'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    pa = a; read_req = 1'b1;
    wait_end("timeout_done", 300);
    read_req = 1'b0;
    idle(4);
    check("timeout_req_cycles", last_req_run, 255);
    check("timeout_resp_drained", exp_resp_q.size(), 0);
    check("timeout_idle_bus_req", bus_req, 1'b0);
    exp_bus_q.delete();
    never_ack = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ctl"}, {bus_req, bus_we, line_write, cache_entry_refill, trans_rdy, bus_error}, 6'h0);
    check({name, "_bus_addr"}, bus_addr, 24'h0);
    check({name, "_bus_wdata"}, bus_wdata, 8'h0);
    check({name, "_line"}, {line_data, addr_count}, 15'h0);
  endtask

  initial begin
    rst = 1'b1;
    read_line_req = 1'b0; read_req = 1'b0; write_through_req = 1'b0;
    pa = 24'h0; wt_data = 8'h0;
    #1 rst = 1'b0;
    #3 check_all_zero("reset");
    idle(2);
    rst = 1'b1;
    idle(2);

    run_line(24'h012345, -1, 1'b0);
    run_single(24'h000010, 1'b1, 1'b0, 8'h00, 8'hA5, 3, 1'b0);
    run_single(24'h00FFFF, 1'b0, 1'b1, 8'h3C, 8'h00, 2, 1'b1);
    run_single(24'h000123, 1'b1, 1'b1, 8'h55, 8'h5A, 0, 1'b0);
    run_line(24'h0ABC80, 40, 1'b1);
    run_timeout(24'h000200);

    // Reset during the second cycle of beat 10 of a fill.
    ack_wait = 1; never_ack = 1'b0; err_beat = -1; rdata_lowaddr = 1'b1;
    beat_idx = 0; lw_count = 0;
    for (int k = 0; k < 128; k++) push_bus(24'h012300 | 24'(k), 1'b0, 8'h00);
    for (int k = 0; k < 10; k++) push_resp(8'(k), 1'b1, 7'(k), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    pa = 24'h012345; read_line_req = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (beat_idx >= 10) break;
    end
    check("rst_reach_beat10", beat_idx, 10);
    @(posedge clk);
    @(posedge clk); #2;
    rst = 1'b0;
    read_line_req = 1'b0;
    #1 check_all_zero("midrst");
    exp_bus_q.delete();
    idle(2);
    check("midrst_lw_count", lw_count, 10);
    check("midrst_resp_drained", exp_resp_q.size(), 0);
    @(posedge clk); #3;
    rst = 1'b1;
    run_single(24'h000044, 1'b1, 1'b0, 8'h00, 8'hC3, 1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule
